// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared constants and types for the FFT stage sequencer
package fft_ctrl_pkg;

    localparam int LOG2N   = 5;
    localparam int N       = 1 << LOG2N;
    localparam int N_HALF  = N / 2;
    localparam int STAGE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

    // One entry of the read-to-write delay line.
    typedef struct packed {
        logic             en;
        logic [LOG2N-1:0] addr_a;
        logic [LOG2N-1:0] addr_b;
        logic             bank;
    } wr_slot_t;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - sequencer control/address bus; stall exists only with FFT_STALL_EN
interface fft_stage_sequencer_if;
    import fft_ctrl_pkg::*;

    logic               start;
`ifdef FFT_STALL_EN
    logic               stall;
`endif
    logic               busy;
    logic               done;
    logic [STAGE_W-1:0] stage;
    logic               rd_en;
    logic [LOG2N-1:0]   rd_addr_a;
    logic [LOG2N-1:0]   rd_addr_b;
    logic               rd_bank;
    logic [LOG2N-2:0]   tw_idx;
    logic               wr_en;
    logic [LOG2N-1:0]   wr_addr_a;
    logic [LOG2N-1:0]   wr_addr_b;
    logic               wr_bank;

    modport master (
`ifdef FFT_STALL_EN
        input  stall,
`endif
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, rd_bank,
        output tw_idx, wr_en, wr_addr_a, wr_addr_b, wr_bank
    );

    modport slave (
`ifdef FFT_STALL_EN
        output stall,
`endif
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, rd_bank,
        input  tw_idx, wr_en, wr_addr_a, wr_addr_b, wr_bank
    );

endinterface

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - combinational radix-2 DIT butterfly address and twiddle index generator
module fft_addr_gen
    import fft_ctrl_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   bf_idx,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic [LOG2N-2:0]   tw_idx
);

    logic [LOG2N-1:0] j_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] low;

    // Upper input inserts a 0 at bit position 'stage' of the butterfly index; lower input sets it.
    always_comb begin
        j_ext  = {1'b0, bf_idx};
        span   = LOG2N'(1) << stage;
        low    = j_ext & (span - LOG2N'(1));
        addr_a = ((j_ext >> stage) << (stage + STAGE_W'(1))) | low;
        addr_b = addr_a + span;
        tw_idx = low[LOG2N-2:0] << (STAGE_W'(LOG2N - 1) - stage);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - 32-point radix-2 DIT stage sequencer; FFT_STALL_EN adds a stall input
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int BFLY_LAT = 3
) (
    input  logic                  clk2,
    input  logic                  rst,
    fft_stage_sequencer_if.master bus
);

    localparam int DRAIN_W = (BFLY_LAT < 2) ? 1 : $clog2(BFLY_LAT);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(BFLY_LAT - 1);
    localparam logic [LOG2N-2:0]     BF_LAST    = (LOG2N-1)'(N_HALF - 1);
    localparam logic [STAGE_W-1:0]   STAGE_LAST = STAGE_W'(LOG2N - 1);

    seq_state_t         state_q, state_d;
    logic [STAGE_W-1:0] stage_cnt_q, stage_cnt_d;
    logic [LOG2N-2:0]   bf_idx_q, bf_idx_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               bank_q, bank_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               rd_en_q, rd_en_d;
    logic [LOG2N-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [LOG2N-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic               rd_bank_q, rd_bank_d;
    logic [LOG2N-2:0]   tw_idx_q, tw_idx_d;

    wr_slot_t [BFLY_LAT-1:0] dl_q, dl_d;
    wr_slot_t                wr_q, wr_d;

    logic [LOG2N-1:0] gen_a, gen_b;
    logic [LOG2N-2:0] gen_tw;
    logic             stall_act;
    logic             issue;

`ifdef FFT_STALL_EN
    assign stall_act = bus.stall && (state_q == ISSUE || state_q == DRAIN);
`else
    assign stall_act = 1'b0;
`endif

    fft_addr_gen u_addr_gen (
        .stage  (stage_cnt_q),
        .bf_idx (bf_idx_q),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_comb begin
        state_d     = state_q;
        stage_cnt_d = stage_cnt_q;
        bf_idx_d    = bf_idx_q;
        drain_cnt_d = drain_cnt_q;
        bank_d      = bank_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = ISSUE;
                    stage_cnt_d = '0;
                    bf_idx_d    = '0;
                    bank_d      = 1'b0;
                end
            end
            ISSUE: begin
                if (bf_idx_q == BF_LAST) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    bf_idx_d = bf_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    if (stage_cnt_q == STAGE_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d     = ISSUE;
                        stage_cnt_d = stage_cnt_q + 1'b1;
                        bf_idx_d    = '0;
                        bank_d      = ~bank_q;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                stage_cnt_d = '0;
                bank_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (stall_act) begin
            state_d     = state_q;
            stage_cnt_d = stage_cnt_q;
            bf_idx_d    = bf_idx_q;
            drain_cnt_d = drain_cnt_q;
            bank_d      = bank_q;
        end

        issue       = (state_q == ISSUE) && !stall_act;
        rd_en_d     = issue;
        rd_addr_a_d = issue ? gen_a  : rd_addr_a_q;
        rd_addr_b_d = issue ? gen_b  : rd_addr_b_q;
        tw_idx_d    = issue ? gen_tw : tw_idx_q;
        stage_d     = stage_cnt_q;
        rd_bank_d   = bank_q;
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == DONE);

        // A frozen delay line keeps its pending writes; only the strobe is masked while stalled.
        dl_d    = dl_q;
        wr_d    = wr_q;
        wr_d.en = 1'b0;
        if (!stall_act) begin
            dl_d[0] = {issue, rd_addr_a_d, rd_addr_b_d, ~bank_q};
            for (int i = 1; i < BFLY_LAT; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            wr_d = dl_q[BFLY_LAT-1];
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_cnt_q <= '0;
            bf_idx_q    <= '0;
            drain_cnt_q <= '0;
            bank_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            rd_bank_q   <= 1'b0;
            tw_idx_q    <= '0;
            dl_q        <= '0;
            wr_q        <= '0;
        end else begin
            state_q     <= state_d;
            stage_cnt_q <= stage_cnt_d;
            bf_idx_q    <= bf_idx_d;
            drain_cnt_q <= drain_cnt_d;
            bank_q      <= bank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_q     <= stage_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            rd_bank_q   <= rd_bank_d;
            tw_idx_q    <= tw_idx_d;
            dl_q        <= dl_d;
            wr_q        <= wr_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.tw_idx    = tw_idx_q;
    assign bus.wr_en     = wr_q.en;
    assign bus.wr_addr_a = wr_q.addr_a;
    assign bus.wr_addr_b = wr_q.addr_b;
    assign bus.wr_bank   = wr_q.bank;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - scoreboard bench for fft_stage_sequencer (stall case with FFT_STALL_EN)
module tb_fft_stage_sequencer;
    import fft_ctrl_pkg::*;

`ifdef FFT_STALL_EN
    localparam bit STALL_RUN = 1'b1;
`else
    localparam bit STALL_RUN = 1'b0;
`endif

    logic clk2 = 1'b0;
    logic rst  = 1'b1;

    fft_stage_sequencer_if bus();

    fft_stage_sequencer #(.BFLY_LAT(3)) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk2 = ~clk2;

    int cyc = 0;
    always @(posedge clk2) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int stage;
        int j;
        int a;
        int b;
        int tw;
        int bank;
    } ev_t;

    ev_t rd_exp[$];
    ev_t wr_exp[$];
    int  done_exp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int obs_a[5][16];
    int obs_b[5][16];
    int obs_tw[5][16];
    int rd_seen = 0, wr_seen = 0, done_seen = 0;
    int last_wr_bank = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event with no pending expectation (cycle %0d)", name, cyc);
    endtask

    // Timeline shift caused by the 4-cycle stall beginning at stage 1 butterfly 7.
    function automatic int adj(input int u, input int k, input bit st);
        return (st && u >= k + 27) ? u + 4 : u;
    endfunction

    task automatic push_run(input int k, input bit st);
        ev_t e;
        for (int s = 0; s < 5; s++) begin
            for (int j = 0; j < 16; j++) begin
                int span, lo, u;
                span   = 1 << s;
                lo     = j % span;
                u      = k + 1 + s * 19 + j;
                e.stage = s;
                e.j     = j;
                e.a     = (j / span) * 2 * span + lo;
                e.b     = e.a + span;
                e.tw    = lo * (16 / span);
                e.bank  = s % 2;
                e.cyc   = adj(u, k, st);
                rd_exp.push_back(e);
                e.bank  = 1 - (s % 2);
                e.cyc   = adj(u + 3, k, st);
                wr_exp.push_back(e);
            end
        end
        done_exp.push_back(adj(k + 96, k, st));
    endtask

    always @(negedge clk2) begin
        ev_t e;
        if (bus.rd_en === 1'b1) begin
            rd_seen++;
            if (rd_exp.size() == 0) unexpected("rd_en");
            else begin
                e = rd_exp.pop_front();
                check("rd_cycle", cyc, e.cyc);
                check("rd_stage", bus.stage, e.stage);
                check("rd_addr_a", bus.rd_addr_a, e.a);
                check("rd_addr_b", bus.rd_addr_b, e.b);
                check("tw_idx", bus.tw_idx, e.tw);
                check("rd_bank", bus.rd_bank, e.bank);
                obs_a[e.stage][e.j]  = bus.rd_addr_a;
                obs_b[e.stage][e.j]  = bus.rd_addr_b;
                obs_tw[e.stage][e.j] = bus.tw_idx;
            end
        end
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            if (wr_exp.size() == 0) unexpected("wr_en");
            else begin
                e = wr_exp.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr_a", bus.wr_addr_a, e.a);
                check("wr_addr_b", bus.wr_addr_b, e.b);
                check("wr_bank", bus.wr_bank, e.bank);
                last_wr_bank = bus.wr_bank;
            end
        end
        if (bus.done === 1'b1) begin
            done_seen++;
            if (done_exp.size() == 0) unexpected("done");
            else begin
                check("done_cycle", cyc, done_exp.pop_front());
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk2);
    endtask

    task automatic pulse_start(output int k);
        check("busy_before_start", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
        k = cyc;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 300 && done_seen == d0; i++) @(negedge clk2);
        check("done_seen", done_seen > d0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_stage"}, bus.stage, 0);
        check({tag, "_rd_addr"}, {bus.rd_addr_a, bus.rd_addr_b}, 0);
        check({tag, "_tw_idx"}, bus.tw_idx, 0);
        check({tag, "_rd_bank"}, bus.rd_bank, 0);
        check({tag, "_wr_addr"}, {bus.wr_addr_a, bus.wr_addr_b, bus.wr_bank}, 0);
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, d0, r0, w0;
        bus.start = 1'b0;
`ifdef FFT_STALL_EN
        bus.stall = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk2);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk2);

        // Run A: re-pulsed start mid-run and in DONE, optional stall.
        d0 = done_seen;
        pulse_start(k);
        push_run(k, STALL_RUN);
        wait_cyc(k + 22);
        bus.start = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
`ifdef FFT_STALL_EN
        wait_cyc(k + 26);
        bus.stall = 1'b1;
        repeat (2) @(negedge clk2);
        check("stall_rd_en", bus.rd_en, 0);
        check("stall_wr_en", bus.wr_en, 0);
        check("stall_bf_idx", dut.bf_idx_q, 7);
        repeat (2) @(negedge clk2);
        bus.stall = 1'b0;
`endif
        wait_cyc(adj(k + 95, k, STALL_RUN));
        bus.start = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
        wait_done(d0);
        r0 = rd_seen;
        repeat (4) @(negedge clk2);
        check("busy_after_done", bus.busy, 0);
        check("no_rd_after_done_start", rd_seen, r0);
        check("rd_queue_empty_a", rd_exp.size(), 0);
        check("wr_queue_empty_a", wr_exp.size(), 0);
        check("rd_count_a", rd_seen, 80);

        for (int j = 0; j < 4; j++) begin
            check("s0_addr_a", obs_a[0][j], 2 * j);
            check("s0_addr_b", obs_b[0][j], 2 * j + 1);
            check("s0_tw", obs_tw[0][j], 0);
        end
        check("s2b5_addr_a", obs_a[2][5], 9);
        check("s2b5_addr_b", obs_b[2][5], 13);
        check("s2b5_tw", obs_tw[2][5], 4);
        check("s4b3_addr_a", obs_a[4][3], 3);
        check("s4b3_addr_b", obs_b[4][3], 19);
        check("s4b3_tw", obs_tw[4][3], 3);
        check("final_wr_bank", last_wr_bank, 1);

        // start and rst together: reset wins.
        r0 = rd_seen;
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk2);
        rst = 1'b0;
        bus.start = 1'b0;
        check("start_rst_busy", bus.busy, 0);
        repeat (5) @(negedge clk2);
        check("start_rst_busy_later", bus.busy, 0);
        check("start_rst_no_rd", rd_seen, r0);

        // Run B: reset at stage 2 butterfly 6.
        pulse_start(k);
        push_run(k, 1'b0);
        wait_cyc(k + 45);
        rst = 1'b1;
        @(negedge clk2);
        check_idle_outputs("midrst");
        rd_exp.delete();
        wr_exp.delete();
        done_exp.delete();
        w0 = wr_seen;
        rst = 1'b0;
        repeat (10) @(negedge clk2);
        check("midrst_no_wr", wr_seen, w0);
        check("midrst_busy", bus.busy, 0);

        // Run C: full run after the aborted one.
        d0 = done_seen;
        r0 = rd_seen;
        pulse_start(k);
        push_run(k, 1'b0);
        wait_done(d0);
        @(negedge clk2);
        check("rd_queue_empty_c", rd_exp.size(), 0);
        check("wr_queue_empty_c", wr_exp.size(), 0);
        check("rd_count_c", rd_seen - r0, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
